// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM generators with bus-written shadow on/off periods,
// per-channel enable/invert and a one-cycle period_done pulse at each boundary.
module pwm_bank #(
  parameter int unsigned          CHANNELS  = 4,
  parameter int unsigned          CNT_WIDTH = 16,
  parameter int unsigned          ADD_WIDTH = 6,
  parameter logic [ADD_WIDTH-1:0] CTRL_ADD  = 'h19,
  parameter logic [ADD_WIDTH-1:0] BASE_ADD  = 'h20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADD_WIDTH-1:0] wr_add,
  input  logic [15:0]          wr_data,
  output logic [CHANNELS-1:0]  pwm_out,
  output logic [CHANNELS-1:0]  period_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_STALL
  } state_t;

  logic [CHANNELS-1:0]  en_q, en_d;
  logic [CHANNELS-1:0]  inv_q, inv_d;
  logic [CNT_WIDTH-1:0] on_sh_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] on_sh_d   [CHANNELS];
  logic [CNT_WIDTH-1:0] off_sh_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] off_sh_d  [CHANNELS];
  logic [CNT_WIDTH-1:0] on_act_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] on_act_d  [CHANNELS];
  logic [CNT_WIDTH-1:0] off_act_q [CHANNELS];
  logic [CNT_WIDTH-1:0] off_act_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q     [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d     [CHANNELS];
  state_t               state_q   [CHANNELS];
  state_t               state_d   [CHANNELS];
  logic [CHANNELS-1:0]  raw_q, raw_d;
  logic [CHANNELS-1:0]  done_q, done_d;
  logic [CHANNELS-1:0]  reload;

  // Register file: control wins if it ever aliases a channel address.
  always_comb begin
    en_d  = en_q;
    inv_d = inv_q;
    if (wr_en && (wr_add == CTRL_ADD)) begin
      en_d  = wr_data[CHANNELS-1:0];
      inv_d = wr_data[8 +: CHANNELS];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      on_sh_d[c]  = on_sh_q[c];
      off_sh_d[c] = off_sh_q[c];
      if (wr_en && (wr_add != CTRL_ADD)) begin
        if (wr_add == (BASE_ADD + ADD_WIDTH'(2 * c)))
          on_sh_d[c] = wr_data[CNT_WIDTH-1:0];
        if (wr_add == (BASE_ADD + ADD_WIDTH'(2 * c + 1)))
          off_sh_d[c] = wr_data[CNT_WIDTH-1:0];
      end
    end
  end

  // Per-channel sequencer; raw output lags the phase state by one edge.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]   = state_q[c];
      cnt_d[c]     = cnt_q[c];
      on_act_d[c]  = on_act_q[c];
      off_act_d[c] = off_act_q[c];
      reload[c]    = 1'b0;
      done_d[c]    = 1'b0;
      raw_d[c]     = en_q[c] && (state_q[c] == ST_ON);
      if (!en_q[c]) begin
        state_d[c] = ST_IDLE;
      end else begin
        case (state_q[c])
          ST_ON: begin
            if (cnt_q[c] != '0) begin
              cnt_d[c] = cnt_q[c] - CNT_WIDTH'(1);
            end else if (off_act_q[c] != '0) begin
              state_d[c] = ST_OFF;
              cnt_d[c]   = off_act_q[c] - CNT_WIDTH'(1);
            end else begin
              reload[c] = 1'b1;
              done_d[c] = 1'b1;
            end
          end
          ST_OFF: begin
            if (cnt_q[c] != '0) begin
              cnt_d[c] = cnt_q[c] - CNT_WIDTH'(1);
            end else begin
              reload[c] = 1'b1;
              done_d[c] = 1'b1;
            end
          end
          default: reload[c] = 1'b1;
        endcase
        // Boundary, idle start and stall all pick the next phase from shadow.
        if (reload[c]) begin
          on_act_d[c]  = on_sh_q[c];
          off_act_d[c] = off_sh_q[c];
          if (on_sh_q[c] != '0) begin
            state_d[c] = ST_ON;
            cnt_d[c]   = on_sh_q[c] - CNT_WIDTH'(1);
          end else if (off_sh_q[c] != '0) begin
            state_d[c] = ST_OFF;
            cnt_d[c]   = off_sh_q[c] - CNT_WIDTH'(1);
          end else begin
            state_d[c] = ST_STALL;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      inv_q  <= '0;
      raw_q  <= '0;
      done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        on_sh_q[c]   <= '0;
        off_sh_q[c]  <= '0;
        on_act_q[c]  <= '0;
        off_act_q[c] <= '0;
        cnt_q[c]     <= '0;
        state_q[c]   <= ST_IDLE;
      end
    end else begin
      en_q   <= en_d;
      inv_q  <= inv_d;
      raw_q  <= raw_d;
      done_q <= done_d;
      for (int c = 0; c < CHANNELS; c++) begin
        on_sh_q[c]   <= on_sh_d[c];
        off_sh_q[c]  <= off_sh_d[c];
        on_act_q[c]  <= on_act_d[c];
        off_act_q[c] <= off_act_d[c];
        cnt_q[c]     <= cnt_d[c];
        state_q[c]   <= state_d[c];
      end
    end
  end

  assign pwm_out     = raw_q ^ inv_q;
  assign period_done = done_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed scenarios and random traffic checked against a
// position-in-period model of each channel.
module tb_pwm_bank;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_add;
  logic [15:0] wr_data;
  logic [3:0]  pwm_out;
  logic [3:0]  period_done;

  int checks = 0;
  int errors = 0;

  pwm_bank dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_add     (wr_add),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_done(period_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: shadow values, the period being played and the position inside it.
  int         m_on_sh [4];
  int         m_off_sh[4];
  int         m_on    [4];
  int         m_off   [4];
  int         m_pos   [4];
  bit         m_run   [4];
  logic [3:0] m_en, m_inv, m_raw, m_done;

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_on_sh[c] = 0; m_off_sh[c] = 0; m_on[c] = 0; m_off[c] = 0;
      m_pos[c] = 0; m_run[c] = 1'b0;
    end
    m_en = '0; m_inv = '0; m_raw = '0; m_done = '0;
  endtask

  task automatic model_load(input int c);
    m_on[c]  = m_on_sh[c];
    m_off[c] = m_off_sh[c];
    m_pos[c] = 0;
    m_run[c] = (m_on[c] + m_off[c]) > 0;
  endtask

  task automatic tick(input bit we, input logic [5:0] addr, input logic [15:0] data);
    int a;
    wr_en = we; wr_add = addr; wr_data = data;
    @(posedge clock);
    for (int c = 0; c < 4; c++) begin
      m_done[c] = 1'b0;
      if (!m_en[c]) begin
        m_run[c] = 1'b0;
        m_raw[c] = 1'b0;
      end else if (!m_run[c]) begin
        m_raw[c] = 1'b0;
        model_load(c);
      end else begin
        m_raw[c] = (m_pos[c] < m_on[c]);
        m_pos[c]++;
        if (m_pos[c] == m_on[c] + m_off[c]) begin
          m_done[c] = 1'b1;
          model_load(c);
        end
      end
    end
    if (we) begin
      a = int'(addr);
      if (a == 'h19) begin
        m_en  = data[3:0];
        m_inv = data[11:8];
      end else if (a >= 'h20 && a < 'h28) begin
        if (a % 2 == 1) m_off_sh[(a - 'h20) / 2] = int'(data);
        else            m_on_sh[(a - 'h20) / 2]  = int'(data);
      end
    end
    #1;
    wr_en = 1'b0;
  endtask

  function automatic logic [3:0] exp_pwm();
    return m_raw ^ m_inv;
  endfunction

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_add = '0; wr_data = '0;
    model_clear();
    #1;
    checks++;
    if (pwm_out !== 4'h0 || period_done !== 4'h0) begin
      errors++;
      $display("FAIL reset_level pwm=%b done=%b want 0000/0000", pwm_out, period_done);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== 4'h0 || period_done !== 4'h0) begin
        errors++;
        $display("FAIL reset_idle pwm=%b done=%b want 0000/0000", pwm_out, period_done);
      end
    end
  endtask

  task automatic test_basic();
    int highs = 0, dones = 0;
    tick(1'b1, 6'h20, 16'd3);
    tick(1'b1, 6'h21, 16'd5);
    tick(1'b1, 6'h19, 16'h0001);
    tick(1'b0, 6'h00, 16'h0);
    checks++;
    if (pwm_out[0] !== 1'b0) begin
      errors++; $display("FAIL basic_first_edge pwm0=%b want 0", pwm_out[0]);
    end
    tick(1'b0, 6'h00, 16'h0);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++; $display("FAIL basic_second_edge pwm0=%b want 1", pwm_out[0]);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      highs += int'(pwm_out[0]);
      dones += int'(period_done[0]);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL basic cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
    checks++;
    if (highs != 6 || dones != 2) begin
      errors++; $display("FAIL basic_counts highs=%0d dones=%0d want 6/2", highs, dones);
    end
  endtask

  task automatic test_midwrite();
    int guard = 0;
    while (!(m_run[0] && m_pos[0] == 1) && guard < 50) begin
      tick(1'b0, 6'h00, 16'h0); guard++;
    end
    tick(1'b1, 6'h20, 16'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL midwrite cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
    guard = 0;
    while (!(m_run[0] && m_pos[0] == m_on[0] + m_off[0] - 1) && guard < 50) begin
      tick(1'b0, 6'h00, 16'h0); guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++; $display("FAIL boundary_wait timeout guard=%0d want <50", guard);
    end
    tick(1'b1, 6'h20, 16'd2);
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL boundary_write cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
  endtask

  task automatic test_zero();
    int highs, dones;
    tick(1'b1, 6'h20, 16'd0);
    tick(1'b1, 6'h21, 16'd4);
    repeat (20) tick(1'b0, 6'h00, 16'h0);
    highs = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      highs += int'(pwm_out[0]); dones += int'(period_done[0]);
    end
    checks++;
    if (highs != 0 || dones != 3) begin
      errors++; $display("FAIL zero_on highs=%0d dones=%0d want 0/3", highs, dones);
    end
    tick(1'b1, 6'h21, 16'd0);
    repeat (20) tick(1'b0, 6'h00, 16'h0);
    highs = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      highs += int'(pwm_out[0]); dones += int'(period_done[0]);
    end
    checks++;
    if (highs != 0 || dones != 0) begin
      errors++; $display("FAIL stall highs=%0d dones=%0d want 0/0", highs, dones);
    end
    tick(1'b1, 6'h20, 16'd2);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL stall_resume cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
  endtask

  task automatic test_invert();
    tick(1'b1, 6'h22, 16'd2);
    tick(1'b1, 6'h23, 16'd2);
    tick(1'b1, 6'h19, 16'h0003);
    repeat (9) tick(1'b0, 6'h00, 16'h0);
    tick(1'b1, 6'h19, 16'h0203);
    checks++;
    if (pwm_out[1] !== ~m_raw[1]) begin
      errors++; $display("FAIL invert_immediate pwm1=%b want %b", pwm_out[1], ~m_raw[1]);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL invert cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
  endtask

  task automatic test_disable();
    int guard = 0;
    tick(1'b1, 6'h21, 16'd3);
    while (!(m_run[0] && m_pos[0] == 0 && m_on[0] == 2 && m_off[0] == 3) && guard < 50) begin
      tick(1'b0, 6'h00, 16'h0); guard++;
    end
    tick(1'b0, 6'h00, 16'h0);
    tick(1'b1, 6'h19, 16'h0202);
    tick(1'b0, 6'h00, 16'h0);
    checks++;
    if (pwm_out[0] !== 1'b0 || period_done[0] !== 1'b0) begin
      errors++; $display("FAIL disable pwm0=%b done0=%b want 0/0", pwm_out[0], period_done[0]);
    end
    repeat (5) tick(1'b0, 6'h00, 16'h0);
    tick(1'b1, 6'h19, 16'h0203);
    tick(1'b0, 6'h00, 16'h0);
    tick(1'b0, 6'h00, 16'h0);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++; $display("FAIL reenable_first pwm0=%b want 1", pwm_out[0]);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL reenable cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 6'h24, 16'd3);
    tick(1'b1, 6'h25, 16'd1);
    tick(1'b1, 6'h26, 16'd1);
    tick(1'b1, 6'h27, 16'd0);
    tick(1'b1, 6'h19, 16'h000F);
    repeat (3) tick(1'b0, 6'h00, 16'h0);
    reset = 1'b1;
    #2;
    model_clear();
    checks++;
    if (pwm_out !== 4'h0 || period_done !== 4'h0) begin
      errors++; $display("FAIL reset_mid pwm=%b done=%b want 0000/0000", pwm_out, period_done);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick(1'b1, 6'h19, 16'h000F);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 6'h00, 16'h0);
      checks++;
      if (pwm_out !== 4'h0 || period_done !== m_done || m_done !== 4'h0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d pwm=%b done=%b want 0000/0000", i, pwm_out, period_done);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       begin a = 6'h19; d = 16'($urandom()); end
          1:       begin a = 6'($urandom_range(0, 63)); d = 16'($urandom_range(0, 5)); end
          default: begin a = 6'(32 + $urandom_range(0, 7)); d = 16'($urandom_range(0, 4)); end
        endcase
        tick(1'b1, a, d);
      end else begin
        tick(1'b0, 6'h00, 16'h0);
      end
      checks++;
      if (pwm_out !== exp_pwm() || period_done !== m_done) begin
        errors++;
        $display("FAIL random cyc=%0d pwm=%b done=%b want %b/%b", i, pwm_out, period_done, exp_pwm(), m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midwrite();
    test_zero();
    test_invert();
    test_disable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
